// File: rtl/regfile_wport_arbiter.sv
// rtl/regfile_wport_arbiter.sv - register-file write-port arbiter: pipeline, 1-entry lu holding buffer, optional clear
// Optional feature macro: REGFILE_CLEAR_EN (zero addresses 1..max after reset)
module regfile_wport_arbiter #(
  parameter int ADDRESS_WIDTH = 5,
  parameter int DATA_WIDTH    = 32,
  parameter int STARVE_LIMIT  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wb_en,
  input  logic [ADDRESS_WIDTH-1:0] wb_ad,
  input  logic [DATA_WIDTH-1:0]    wb_wd,
  input  logic                     lu_valid,
  output logic                     lu_ready,
  input  logic [ADDRESS_WIDTH-1:0] lu_ad,
  input  logic [DATA_WIDTH-1:0]    lu_wd,
  output logic                     we3,
  output logic [ADDRESS_WIDTH-1:0] ad3,
  output logic [DATA_WIDTH-1:0]    wd3,
  output logic                     lu_pend,
  output logic [ADDRESS_WIDTH-1:0] lu_pend_ad,
  output logic                     stall_req,
  output logic                     busy
);

  typedef enum logic [1:0] {INIT, IDLE, HELD} state_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t                  state;
  logic [ADDRESS_WIDTH-1:0] buf_ad;
  logic [DATA_WIDTH-1:0]    buf_wd;
  logic [3:0]               age;
  logic [3:0]               age_nxt;
  logic                     pipe_req;
  logic                     lu_wr;

`ifdef REGFILE_CLEAR_EN
  logic [ADDRESS_WIDTH-1:0] clr_ad;
  localparam state_t RESET_STATE = INIT;
  assign busy = (state == INIT);
`else
  localparam state_t RESET_STATE = IDLE;
  assign busy = 1'b0;
`endif

  // IDLE is the only state that is both out of INIT and has an empty buffer.
  assign lu_ready   = (state == IDLE);
  assign pipe_req   = wb_en && (wb_ad != '0) && (state != INIT);
  assign lu_wr      = lu_valid && lu_ready && (lu_ad != '0);
  assign lu_pend    = (state == HELD);
  assign lu_pend_ad = buf_ad;
  assign age_nxt    = (age == 4'hF) ? age : age + 4'd1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= RESET_STATE;
      we3       <= 1'b0;
      ad3       <= '0;
      wd3       <= '0;
      buf_ad    <= '0;
      buf_wd    <= '0;
      age       <= '0;
      stall_req <= 1'b0;
`ifdef REGFILE_CLEAR_EN
      clr_ad    <= ADDRESS_WIDTH'(1);
`endif
    end else begin
      we3 <= 1'b0;
      case (state)
        INIT: begin
`ifdef REGFILE_CLEAR_EN
          // clr_ad wraps to 0 after the top address; that extra cycle keeps busy over the last write.
          if (clr_ad != '0) begin
            we3    <= 1'b1;
            ad3    <= clr_ad;
            wd3    <= '0;
            clr_ad <= clr_ad + ADDRESS_WIDTH'(1);
          end else begin
            state <= IDLE;
          end
`else
          state <= IDLE;
`endif
        end
        IDLE: begin
          if (pipe_req) begin
            we3 <= 1'b1;
            ad3 <= wb_ad;
            wd3 <= wb_wd;
            if (lu_wr) begin
              buf_ad <= lu_ad;
              buf_wd <= lu_wd;
              state  <= HELD;
            end
          end else if (lu_wr) begin
            we3 <= 1'b1;
            ad3 <= lu_ad;
            wd3 <= lu_wd;
          end
        end
        HELD: begin
          if (pipe_req) begin
            we3       <= 1'b1;
            ad3       <= wb_ad;
            wd3       <= wb_wd;
            age       <= age_nxt;
            stall_req <= (age_nxt >= LIMIT);
          end else begin
            we3       <= 1'b1;
            ad3       <= buf_ad;
            wd3       <= buf_wd;
            buf_ad    <= '0;
            age       <= '0;
            stall_req <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/regfile_wport_arbiter.md
REGFILE_WPORT_ARBITER -- requirements
Module: regfile_wport_arbiter

Interface
REQ-001 SHALL have parameter ADDRESS_WIDTH, default 5: register address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: register data width.
REQ-003 SHALL have parameter STARVE_LIMIT, default 4: number of lost arbitration cycles before stall_req asserts, range 1..15.
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port wb_en  input  1  pipeline writeback request, no handshake.
REQ-007 SHALL have port wb_ad  input  ADDRESS_WIDTH  pipeline destination register.
REQ-008 SHALL have port wb_wd  input  DATA_WIDTH  pipeline write data.
REQ-009 SHALL have port lu_valid  input  1  long-latency unit write request.
REQ-010 SHALL have port lu_ready  output  1  long-latency request accepted this cycle when lu_valid is also high.
REQ-011 SHALL have port lu_ad  input  ADDRESS_WIDTH  long-latency destination register.
REQ-012 SHALL have port lu_wd  input  DATA_WIDTH  long-latency write data.
REQ-013 SHALL have port we3  output  1  register-file write enable.
REQ-014 SHALL have port ad3  output  ADDRESS_WIDTH  register-file write address.
REQ-015 SHALL have port wd3  output  DATA_WIDTH  register-file write data.
REQ-016 SHALL have port lu_pend  output  1  holding buffer occupied.
REQ-017 SHALL have port lu_pend_ad  output  ADDRESS_WIDTH  holding-buffer destination, for decode hazard checks.
REQ-018 SHALL have port stall_req  output  1  request for the pipeline to hold wb_en low next cycle.
REQ-019 SHALL have port busy  output  1  clear sequence in progress.

Function
REQ-020 SHALL register we3/ad3/wd3, giving a 1-cycle latency from the selected request to the write-port outputs.
REQ-021 SHALL treat any request with address 0 as a non-write: it occupies no port slot and never drives we3.
REQ-022 SHALL use fixed priority each cycle: pipeline (wb_en, nonzero wb_ad), then buffer, then direct lu handshake.
REQ-023 SHALL drive lu_ready = (state != INIT) and (buffer empty).
REQ-024 SHALL send an lu handshake straight to the outputs when the pipeline is idle and the buffer is empty; otherwise a nonzero lu handshake loads the 1-entry buffer.
REQ-025 SHALL accept and discard an lu handshake with lu_ad = 0, leaving the buffer empty.
REQ-026 SHALL implement states INIT, IDLE (buffer empty) and HELD (buffer full): IDLE->HELD on a buffered capture; HELD->IDLE when the buffer wins arbitration; INIT->IDLE on clear completion.
REQ-027 SHALL increment a saturating age counter each HELD cycle the buffer loses, and clear it on drain.
REQ-028 SHALL assert stall_req when in HELD and age >= STARVE_LIMIT; if wb_en is still high, the pipeline still wins and stall_req stays high.
REQ-029 SHALL drive lu_pend high exactly in HELD, with lu_pend_ad = buffered address (0 otherwise).
REQ-030 SHALL write the pipeline value and leave the buffer pending when wb_ad equals the buffered address; pipeline ordering is the pipeline's responsibility, using lu_pend_ad.

Reset
REQ-031 SHALL, while rst_n=0 at a clock edge, clear we3, ad3, wd3, lu_pend, lu_pend_ad, stall_req and age to 0, empty the buffer, and set state to INIT (macro defined) or IDLE (macro undefined).
REQ-032 SHALL discard any buffered request on a reset mid-operation, with no write issued.

Configuration
REQ-033 SHALL, with REGFILE_CLEAR_EN defined, run INIT after reset: write 0 to addresses 1..2**ADDRESS_WIDTH-1, one per cycle in ascending order, with busy=1, lu_ready=0 and wb_en ignored; enter IDLE in the cycle after the last write.
REQ-034 SHALL, with REGFILE_CLEAR_EN undefined, tie busy to 0, omit INIT and leave state in IDLE after reset.

Verification
REQ-035 SHALL cover: wb_en=1, wb_ad=5, wb_wd=0xDEADBEEF -> next cycle we3=1, ad3=5, wd3=0xDEADBEEF.
REQ-036 SHALL cover: wb_en=1 (ad 3) and lu handshake (ad 7, wd 0x11) in the same cycle -> ad3=3 first; lu_pend=1, lu_pend_ad=7, lu_ready=0; first cycle with wb_en=0 -> next cycle ad3=7, wd3=0x11, lu_pend=0.
REQ-037 SHALL cover: buffer held while wb_en=1 continuously with STARVE_LIMIT=4 -> stall_req=1 from the 5th HELD cycle; drop wb_en -> buffer drains and stall_req=0.
REQ-038 SHALL cover: wb_en=1 with wb_ad=0 and lu handshake lu_ad=9 -> next cycle we3=1, ad3=9; separately, lu_ad=0 -> handshake completes, we3 stays 0.
REQ-039 SHALL cover, with REGFILE_CLEAR_EN: release rst_n -> 31 consecutive writes of 0 to ad3=1..31 with busy=1; then busy=0, lu_ready=1; reset asserted mid-sequence -> sequence restarts at ad3=1.
